// File: rtl/transistor_drv_pkg.sv
// Shared types and helpers for the transistor pump/valve driver.
package transistor_drv_pkg;

  typedef enum logic [2:0] {
    DRV_OFF,
    DRV_SOFT_START,
    DRV_ON,
    DRV_COOLDOWN,
    DRV_FAULT
  } drv_state_t;

  // Width of a counter that must hold 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/transistor_drv_channel.sv
// One driver channel: FSM, soft-start duty ramp, cooldown and (TRANSISTOR_DRV_FAULT_EN) max-run timeout.
module transistor_drv_channel
  import transistor_drv_pkg::*;
#(
  parameter int PWM_BITS      = 4,
  parameter int RAMP_TICKS    = 8,
  parameter int MAX_ON_TICKS  = 60000,
  parameter int MIN_OFF_TICKS = 2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                req,
  input  logic                fault_clr,
  output logic                drive,
  output logic                active,
  output logic                fault
);

  localparam int RW        = cnt_w(RAMP_TICKS);
  localparam int OW        = cnt_w(MIN_OFF_TICKS);
  localparam int RAMP_LAST = (RAMP_TICKS > 0) ? RAMP_TICKS - 1 : 0;
  localparam int OFF_LAST  = (MIN_OFF_TICKS > 0) ? MIN_OFF_TICKS - 1 : 0;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  drv_state_t          st, st_n;
  logic [PWM_BITS-1:0] duty, duty_n;
  logic [RW-1:0]       ramp_cnt, ramp_n;
  logic [OW-1:0]       off_cnt, off_n;
  logic [PWM_BITS-1:0] pwm_nxt;
  logic                run_timeout;

`ifdef TRANSISTOR_DRV_FAULT_EN
  localparam int NW      = cnt_w(MAX_ON_TICKS);
  localparam int ON_LAST = (MAX_ON_TICKS > 0) ? MAX_ON_TICKS - 1 : 0;
  logic [NW-1:0] on_cnt, on_n;

  assign run_timeout = tick && (on_cnt == NW'(ON_LAST));
`else
  localparam int unused_max_on = MAX_ON_TICKS;
  logic unused_fault_clr;

  assign unused_fault_clr = fault_clr;
  assign run_timeout      = 1'b0;
`endif

  // Drive is registered from next state, so compare against the pwm value visible after the edge.
  assign pwm_nxt = pwm_cnt + PWM_BITS'(1);

  always_comb begin
    st_n   = st;
    duty_n = duty;
    ramp_n = ramp_cnt;
    off_n  = off_cnt;
`ifdef TRANSISTOR_DRV_FAULT_EN
    on_n   = on_cnt;
`endif
    case (st)
      DRV_OFF: if (req) begin
        st_n   = DRV_SOFT_START;
        duty_n = PWM_BITS'(1);
        ramp_n = '0;
`ifdef TRANSISTOR_DRV_FAULT_EN
        on_n   = '0;
`endif
      end
      DRV_SOFT_START, DRV_ON: begin
        if (run_timeout) begin
          st_n = DRV_FAULT;
        end else if (!req) begin
          st_n  = DRV_COOLDOWN;
          off_n = '0;
        end else if (tick) begin
`ifdef TRANSISTOR_DRV_FAULT_EN
          if (on_cnt != '1) on_n = on_cnt + NW'(1);
`endif
          if (st == DRV_SOFT_START) begin
            if (ramp_cnt == RW'(RAMP_LAST)) begin
              ramp_n = '0;
              if (duty == DUTY_MAX) st_n = DRV_ON;
              else                  duty_n = duty + PWM_BITS'(1);
            end else begin
              ramp_n = ramp_cnt + RW'(1);
            end
          end
        end
      end
      DRV_COOLDOWN: begin
        if (MIN_OFF_TICKS == 0) begin
          st_n = DRV_OFF;
        end else if (tick) begin
          if (off_cnt == OW'(OFF_LAST)) st_n  = DRV_OFF;
          else                          off_n = off_cnt + OW'(1);
        end
      end
`ifdef TRANSISTOR_DRV_FAULT_EN
      DRV_FAULT: if (fault_clr) begin
        st_n  = DRV_COOLDOWN;
        off_n = '0;
      end
`endif
      default: st_n = DRV_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= DRV_OFF;
      duty     <= '0;
      ramp_cnt <= '0;
      off_cnt  <= '0;
      drive    <= 1'b0;
    end else begin
      st       <= st_n;
      duty     <= duty_n;
      ramp_cnt <= ramp_n;
      off_cnt  <= off_n;
      drive    <= (st_n == DRV_ON) || ((st_n == DRV_SOFT_START) && (duty_n > pwm_nxt));
    end
  end

`ifdef TRANSISTOR_DRV_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) on_cnt <= '0;
    else        on_cnt <= on_n;
  end

  assign fault = (st == DRV_FAULT);
`else
  assign fault = 1'b0;
`endif

  assign active = (st == DRV_SOFT_START) || (st == DRV_ON);

endmodule

// File: rtl/transistor_pump_driver.sv
// Multi-channel transistor driver top: shared tick prescaler and PWM counter feeding N_CH channels.
// Optional max-run fault timeout enabled by defining TRANSISTOR_DRV_FAULT_EN.
module transistor_pump_driver
  import transistor_drv_pkg::*;
#(
  parameter int N_CH          = 5,
  parameter int CLK_DIV       = 50000,
  parameter int PWM_BITS      = 4,
  parameter int RAMP_TICKS    = 8,
  parameter int MAX_ON_TICKS  = 60000,
  parameter int MIN_OFF_TICKS = 2000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] fault_clr,
  output logic [N_CH-1:0] drive,
  output logic [N_CH-1:0] active,
  output logic [N_CH-1:0] fault
);

  localparam int PW = cnt_w(CLK_DIV - 1);

  logic [PW-1:0]       presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;

  assign tick = (presc == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    transistor_drv_channel #(
      .PWM_BITS      (PWM_BITS),
      .RAMP_TICKS    (RAMP_TICKS),
      .MAX_ON_TICKS  (MAX_ON_TICKS),
      .MIN_OFF_TICKS (MIN_OFF_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .pwm_cnt   (pwm_cnt),
      .req       (req[g]),
      .fault_clr (fault_clr[g]),
      .drive     (drive[g]),
      .active    (active[g]),
      .fault     (fault[g])
    );
  end

endmodule

// File: tb/tb_transistor_pump_driver.sv
// Bench for transistor_pump_driver: directed scenarios plus random req/fault_clr against a tick-level model.
module tb_transistor_pump_driver;
  localparam int N_CH = 2, CLK_DIV = 4, PWM_BITS = 2, RAMP_TICKS = 1;
  localparam int MAX_ON_TICKS = 20, MIN_OFF_TICKS = 5;
  localparam int PWM_PERIOD = 1 << PWM_BITS;
`ifdef TRANSISTOR_DRV_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif
  localparam int IDLE = 0, RAMP = 1, FULL = 2, REST = 3, HALT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N_CH-1:0] req, fault_clr, drive, active, fault;

  always #5 clk = ~clk;

  transistor_pump_driver #(
    .N_CH(N_CH), .CLK_DIV(CLK_DIV), .PWM_BITS(PWM_BITS), .RAMP_TICKS(RAMP_TICKS),
    .MAX_ON_TICKS(MAX_ON_TICKS), .MIN_OFF_TICKS(MIN_OFF_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .fault_clr(fault_clr),
    .drive(drive), .active(active), .fault(fault)
  );

  // Model: edges since reset give both the pwm phase and the tick phase.
  int mode [N_CH];
  int duty [N_CH];
  int steps[N_CH];
  int run  [N_CH];
  int rest [N_CH];
  int cyc;
  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    cyc = 0;
    for (int c = 0; c < N_CH; c++) begin
      mode[c] = IDLE; duty[c] = 0; steps[c] = 0; run[c] = 0; rest[c] = 0;
    end
  endtask

  task automatic model_update();
    bit tk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk = (cyc % CLK_DIV) == CLK_DIV - 1;
    cyc++;
    for (int c = 0; c < N_CH; c++) begin
      case (mode[c])
        IDLE: if (req[c]) begin
          mode[c] = RAMP; duty[c] = 1; steps[c] = 0; run[c] = 0;
        end
        RAMP, FULL: begin
          if (FAULT_EN && tk && run[c] + 1 == MAX_ON_TICKS) mode[c] = HALT;
          else if (!req[c]) begin
            mode[c] = REST; rest[c] = 0;
          end else if (tk) begin
            run[c]++;
            if (mode[c] == RAMP) begin
              steps[c]++;
              if (steps[c] == RAMP_TICKS) begin
                steps[c] = 0;
                if (duty[c] == PWM_PERIOD - 1) mode[c] = FULL;
                else duty[c]++;
              end
            end
          end
        end
        REST: begin
          if (MIN_OFF_TICKS == 0) mode[c] = IDLE;
          else if (tk) begin
            rest[c]++;
            if (rest[c] == MIN_OFF_TICKS) mode[c] = IDLE;
          end
        end
        HALT: if (fault_clr[c]) begin
          mode[c] = REST; rest[c] = 0;
        end
        default: mode[c] = IDLE;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [N_CH-1:0] e_drv, e_act, e_flt;
    for (int c = 0; c < N_CH; c++) begin
      e_drv[c] = (mode[c] == FULL) || (mode[c] == RAMP && duty[c] > (cyc % PWM_PERIOD));
      e_act[c] = (mode[c] == RAMP) || (mode[c] == FULL);
      e_flt[c] = (mode[c] == HALT);
    end
    check("drive", 32'(drive), 32'(e_drv));
    check("active", 32'(active), 32'(e_act));
    check("fault", 32'(fault), 32'(e_flt));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
    end
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; req = 2'b11; fault_clr = 2'b00;
    model_reset();
    step(3);
    check("reset_drive", 32'(drive), 0);
    check("reset_active", 32'(active), 0);
    check("reset_fault", 32'(fault), 0);

    rst_n = 1'b1;
    step(1);
    check("release_active", 32'(active), 32'h3);
    check("model_accept_duty", 32'(duty[0]), 1);

    // Ramp on ch0; ch1 drops into cooldown.
    req = 2'b01;
    step(15);
    check("ramp_model_on", 32'(mode[0]), FULL);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("on_steady", 32'(drive[0]), 1);
    end

    // Cooldown lockout.
    req = 2'b00;
    step(1);
    check("cool_drive_off", 32'(drive[0]), 0);
    req = 2'b01;
    step(12);
    check("cool_ignore_req", 32'(active[0]), 0);
    step(12);
    check("cool_reaccept", 32'(active[0]), 1);

    // Drop during ramp at duty 2.
    waited = 0;
    while (!(mode[0] == RAMP && duty[0] == 2) && waited < 40) begin
      step(1);
      waited++;
    end
    check("duty2_reached", 32'(waited < 40), 1);
    req = 2'b00;
    step(1);
    check("drop_drive", 32'(drive[0]), 0);
    check("drop_active", 32'(active[0]), 0);

    // Max-run timeout on ch1.
    step(24);
    req = 2'b10;
    step(70);
    check("pre_timeout_fault", 32'(fault[1]), 0);
    check("pre_timeout_active", 32'(active[1]), 1);
    step(14);
    check("timeout_fault", 32'(fault[1]), 32'(FAULT_EN));
    check("timeout_drive", 32'(drive[1]), 32'(!FAULT_EN));
    fault_clr = 2'b10;
    step(1);
    fault_clr = 2'b00;
    check("clr_fault", 32'(fault[1]), 0);
    step(24);
    check("clr_reaccept", 32'(active[1]), 1);

    // Async reset with ch0 ON and ch1 cooling down.
    req = 2'b00;
    step(30);
    req = 2'b01;
    step(20);
    check("ind_ch0_on", 32'(mode[0]), FULL);
    req = 2'b11;
    step(2);
    req = 2'b01;
    step(1);
    check("ind_ch1_cool", 32'(mode[1]), REST);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_rst_drive", 32'(drive), 0);
    check("async_rst_active", 32'(active), 0);
    step(2);
    rst_n = 1'b1;

    // Random traffic with long holds so ramps, runs and timeouts all occur.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 39) == 0) req[c] = ~req[c];
        fault_clr[c] = ($urandom_range(0, 15) == 0);
      end
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
